// File: rtl/hyperbus_tgen_pkg.sv
// Shared types for the hyperbus AXI traffic generator: FSM states, AXI channel structs, data pattern.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hyperbus_tgen_pkg;

    localparam int unsigned PageBytes     = 4096;
    localparam int unsigned TgenAddrWidth = 32;
    localparam int unsigned TgenDataWidth = 128;
    localparam int unsigned TgenIdWidth   = 6;

    localparam logic [1:0] AxiBurstIncr = 2'b01;
    localparam logic [1:0] AxiRespOkay  = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_AR,
        ST_R,
        ST_NEXT,
        ST_FIN
    } tgen_state_e;

    typedef struct packed {
        logic [TgenIdWidth-1:0]   id;
        logic [TgenAddrWidth-1:0] addr;
        logic [7:0]               len;
        logic [2:0]               size;
        logic [1:0]               burst;
    } axi_ax_t;

    typedef struct packed {
        logic [TgenDataWidth-1:0]   data;
        logic [TgenDataWidth/8-1:0] strb;
        logic                       last;
    } axi_w_t;

    typedef struct packed {
        logic [TgenIdWidth-1:0] id;
        logic [1:0]             resp;
    } axi_b_t;

    typedef struct packed {
        logic [TgenIdWidth-1:0]   id;
        logic [TgenDataWidth-1:0] data;
        logic [1:0]               resp;
        logic                     last;
    } axi_r_t;

    typedef struct packed {
        logic    aw_valid;
        axi_ax_t aw;
        logic    w_valid;
        axi_w_t  w;
        logic    b_ready;
        logic    ar_valid;
        axi_ax_t ar;
        logic    r_ready;
    } tgen_axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        logic    b_valid;
        axi_b_t  b;
        logic    ar_ready;
        logic    r_valid;
        axi_r_t  r;
    } tgen_axi_rsp_t;

    // One 32-bit lane of test data: its own byte address scrambled by the run seed.
    function automatic logic [31:0] pattern_word(input logic [31:0] addr, input logic [31:0] seed);
        return addr ^ seed;
    endfunction

endpackage

// File: rtl/hyperbus_tgen_addr_seq.sv
// Burst start-address sequencer: next address with 4 KiB page skip and region wrap.
// Latency: combinational.
// Backpressure: none; the caller registers the result when it advances.
module hyperbus_tgen_addr_seq
    import hyperbus_tgen_pkg::*;
#(
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned RegionBytes = 32'h100_0000
) (
    input  logic                 first,
    input  logic [AddrWidth-1:0] base_addr,
    input  logic [AddrWidth-1:0] cur_addr,
    input  logic [AddrWidth-1:0] burst_bytes,
    output logic [AddrWidth-1:0] next_addr
);

    localparam logic [AddrWidth-1:0] PageMask  = AddrWidth'(PageBytes - 1);
    localparam logic [AddrWidth-1:0] PageSize  = AddrWidth'(PageBytes);
    localparam logic [AddrWidth-1:0] RegionEnd = AddrWidth'(RegionBytes);

    logic [AddrWidth-1:0] cand;
    logic [AddrWidth-1:0] page_off;
    logic [AddrWidth-1:0] page_next;
    logic [AddrWidth-1:0] skipped;

    // Candidate is the run base or the address just past the current burst. A burst
    // that would straddle a page moves to the next page start. The controller only
    // decodes NumChips*ChipBytes bytes, so anything at or beyond that (which covers
    // everything past base+region) wraps back to the run base.
    always_comb begin
        cand      = first ? base_addr : cur_addr + burst_bytes;
        page_off  = cand & PageMask;
        page_next = (cand & ~PageMask) + PageSize;
        skipped   = (page_off + burst_bytes > PageSize) ? page_next : cand;
        next_addr = (skipped >= RegionEnd) ? base_addr : skipped;
    end

endmodule

// File: rtl/hyperbus_axi_traffic_gen.sv
// AXI4 write/read-back traffic generator and data checker for the hyperbus controller.
// Latency: one AW/W/B/AR/R sequence per burst, one transaction outstanding; done one cycle after last burst.
// Backpressure: every valid is held with a stable payload until its ready; bready/rready always high when waiting.
module hyperbus_axi_traffic_gen
    import hyperbus_tgen_pkg::*;
#(
    parameter int unsigned NumChips     = 2,
    parameter int unsigned ChipBytes    = 32'h80_0000,
    parameter int unsigned AxiAddrWidth = 32,
    parameter int unsigned AxiDataWidth = 128,
    parameter int unsigned AxiIdWidth   = 6,
    parameter int unsigned MaxBurstLen  = 15,
    parameter type axi_req_t = tgen_axi_req_t,
    parameter type axi_rsp_t = tgen_axi_rsp_t
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [AxiAddrWidth-1:0] base_addr_i,
    input  logic [15:0]             num_bursts_i,
    input  logic [7:0]              burst_len_i,
    input  logic [31:0]             seed_i,
    output axi_req_t                axi_req_o,
    input  axi_rsp_t                axi_rsp_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [15:0]             err_cnt_o,
    output logic [AxiAddrWidth-1:0] first_err_addr_o
);

    localparam int unsigned DataBytes = AxiDataWidth / 8;
    localparam int unsigned SizeLog2  = $clog2(DataBytes);
    localparam int          Lanes     = AxiDataWidth / 32;
    localparam logic [7:0]  MaxLen    = 8'(MaxBurstLen);
    localparam logic [AxiAddrWidth-1:0] AlignMask = ~AxiAddrWidth'(DataBytes - 1);

    tgen_state_e state_q, state_d;

    logic [AxiAddrWidth-1:0] base_q;
    logic [AxiAddrWidth-1:0] cur_addr_q;
    logic [15:0]             num_q;
    logic [15:0]             burst_cnt_q;
    logic [7:0]              len_q;
    logic [7:0]              beat_q;
    logic [31:0]             seed_q;
    logic [15:0]             err_cnt_q;
    logic [AxiAddrWidth-1:0] first_err_addr_q;

    logic                    in_idle;
    logic                    start_ok;
    logic [7:0]              len_in;
    logic [7:0]              len_sel;
    logic [AxiAddrWidth-1:0] base_in;
    logic [AxiAddrWidth-1:0] burst_bytes;
    logic [AxiAddrWidth-1:0] next_addr;
    logic [AxiAddrWidth-1:0] beat_addr;
    logic [AxiDataWidth-1:0] exp_data;
    logic                    last_beat;
    logic                    w_fire, b_fire, r_fire;
    logic                    r_bad, b_bad, err_evt;
    logic [AxiAddrWidth-1:0] err_addr;
    logic                    unused_rsp_id;

    assign in_idle   = (state_q == ST_IDLE);
    assign start_ok  = in_idle & start_i;
    assign len_in    = (burst_len_i > MaxLen) ? MaxLen : burst_len_i;
    assign len_sel   = in_idle ? len_in : len_q;
    assign base_in   = base_addr_i & AlignMask;
    assign burst_bytes = (AxiAddrWidth'(len_sel) + AxiAddrWidth'(1)) << SizeLog2;
    assign beat_addr = cur_addr_q + (AxiAddrWidth'(beat_q) << SizeLog2);
    assign last_beat = (beat_q == len_q);

    assign w_fire = (state_q == ST_W) & axi_rsp_i.w_ready;
    assign b_fire = (state_q == ST_B) & axi_rsp_i.b_valid;
    assign r_fire = (state_q == ST_R) & axi_rsp_i.r_valid;

    // IDs are fixed at zero and never inspected on the way back.
    assign unused_rsp_id = ^{axi_rsp_i.b.id, axi_rsp_i.r.id};

    hyperbus_tgen_addr_seq #(
        .AddrWidth   (AxiAddrWidth),
        .RegionBytes (NumChips * ChipBytes)
    ) u_addr_seq (
        .first       (in_idle),
        .base_addr   (in_idle ? base_in : base_q),
        .cur_addr    (cur_addr_q),
        .burst_bytes (burst_bytes),
        .next_addr   (next_addr)
    );

    // Expected beat data; the same words are written and later demanded on read.
    always_comb begin
        exp_data = '0;
        for (int k = 0; k < Lanes; k++) begin
            exp_data[k*32 +: 32] = pattern_word(beat_addr[31:0] + 32'(4 * k), seed_q);
        end
    end

    // Classify the current response beat; a B error is booked against the burst start.
    always_comb begin
        r_bad    = (axi_rsp_i.r.resp != AxiRespOkay) | (axi_rsp_i.r.data != exp_data) |
                   (axi_rsp_i.r.last != last_beat);
        b_bad    = (axi_rsp_i.b.resp != AxiRespOkay);
        err_evt  = (r_fire & r_bad) | (b_fire & b_bad);
        err_addr = b_fire ? cur_addr_q : beat_addr;
    end

    // State register; reset aborts any run without waiting for the slave.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state and AXI drive: valids depend on state only, never on a ready.
    always_comb begin
        state_d   = state_q;
        axi_req_o = '0;

        axi_req_o.aw.id    = '0;
        axi_req_o.aw.addr  = cur_addr_q;
        axi_req_o.aw.len   = len_q;
        axi_req_o.aw.size  = 3'(SizeLog2);
        axi_req_o.aw.burst = AxiBurstIncr;
        axi_req_o.ar       = axi_req_o.aw;
        axi_req_o.w.data   = exp_data;
        axi_req_o.w.strb   = '1;
        axi_req_o.w.last   = last_beat;

        busy_o = !in_idle;
        done_o = (state_q == ST_FIN);

        case (state_q)
            ST_IDLE: if (start_i) state_d = (num_bursts_i == 16'd0) ? ST_FIN : ST_AW;
            ST_AW: begin
                axi_req_o.aw_valid = 1'b1;
                if (axi_rsp_i.aw_ready) state_d = ST_W;
            end
            ST_W: begin
                axi_req_o.w_valid = 1'b1;
                if (w_fire && last_beat) state_d = ST_B;
            end
            ST_B: begin
                axi_req_o.b_ready = 1'b1;
                if (axi_rsp_i.b_valid) state_d = ST_AR;
            end
            ST_AR: begin
                axi_req_o.ar_valid = 1'b1;
                if (axi_rsp_i.ar_ready) state_d = ST_R;
            end
            ST_R: begin
                axi_req_o.r_ready = 1'b1;
                if (r_fire && last_beat) state_d = ST_NEXT;
            end
            ST_NEXT: state_d = (burst_cnt_q + 16'd1 == num_q) ? ST_FIN : ST_AW;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Run context, beat counter, burst advance and saturating error bookkeeping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            base_q           <= '0;
            cur_addr_q       <= '0;
            num_q            <= '0;
            burst_cnt_q      <= '0;
            len_q            <= '0;
            beat_q           <= '0;
            seed_q           <= '0;
            err_cnt_q        <= '0;
            first_err_addr_q <= '0;
        end else begin
            if (start_ok) begin
                base_q           <= base_in;
                cur_addr_q       <= next_addr;
                num_q            <= num_bursts_i;
                burst_cnt_q      <= '0;
                len_q            <= len_in;
                beat_q           <= '0;
                seed_q           <= seed_i;
                err_cnt_q        <= '0;
                first_err_addr_q <= '0;
            end
            if (w_fire || r_fire) beat_q <= last_beat ? 8'd0 : beat_q + 8'd1;
            if (state_q == ST_NEXT) begin
                burst_cnt_q <= burst_cnt_q + 16'd1;
                cur_addr_q  <= next_addr;
            end
            if (err_evt) begin
                if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
                if (err_cnt_q == 16'd0) first_err_addr_q <= err_addr;
            end
        end
    end

    assign err_cnt_o        = err_cnt_q;
    assign first_err_addr_o = first_err_addr_q;

endmodule

// File: tb/tb_hyperbus_axi_traffic_gen.sv
// Scoreboard bench: AXI slave model with stall/error/corruption knobs, queued expectations.
// Latency: n/a.
// Backpressure: slave can stall W to hold the generator mid-burst.
module tb_hyperbus_axi_traffic_gen;
    import hyperbus_tgen_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [31:0]   base;
    logic [15:0]   num;
    logic [7:0]    blen;
    logic [31:0]   seed;
    tgen_axi_req_t req;
    tgen_axi_rsp_t rsp;
    logic          busy, done;
    logic [15:0]   err_cnt;
    logic [31:0]   first_err;

    int checks = 0;
    int failures = 0;
    int done_count = 0;

    logic [39:0]  exp_aw_q[$];
    logic [39:0]  exp_ar_q[$];
    logic [128:0] exp_w_q[$];
    logic [47:0]  exp_done_q[$];

    // slave model state and knobs
    logic [127:0] mem [logic [31:0]];
    logic         w_stall = 1'b0;
    logic         force_slverr = 1'b0;
    logic         inj_en = 1'b0;
    logic [31:0]  inj_addr = '0;
    logic [31:0]  wr_addr, ar_addr, rd_a;
    logic [7:0]   ar_len;
    logic [127:0] rd;
    int           wr_beat, r_beat;
    logic         b_pend, r_active;

    hyperbus_axi_traffic_gen dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .start_i          (start),
        .base_addr_i      (base),
        .num_bursts_i     (num),
        .burst_len_i      (blen),
        .seed_i           (seed),
        .axi_req_o        (req),
        .axi_rsp_i        (rsp),
        .busy_o           (busy),
        .done_o           (done),
        .err_cnt_o        (err_cnt),
        .first_err_addr_o (first_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got handshake expected none", name);
    endtask

    function automatic logic [127:0] pat(input logic [31:0] a, input logic [31:0] s);
        logic [127:0] d;
        for (int k = 0; k < 4; k++) d[k*32 +: 32] = (a + 32'(4 * k)) ^ s;
        return d;
    endfunction

    task automatic push_burst(input logic [31:0] a, input logic [7:0] l, input logic [31:0] s);
        exp_aw_q.push_back({a, l});
        exp_ar_q.push_back({a, l});
        for (int b = 0; b <= int'(l); b++)
            exp_w_q.push_back({b == int'(l), pat(a + 32'(b * 16), s)});
    endtask

    task automatic start_run(input logic [31:0] b, input logic [15:0] n, input logic [7:0] l,
                             input logic [31:0] s);
        @(negedge clk);
        base = b; num = n; blen = l; seed = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_wait(input int dc, input int budget, input string tag);
        int n;
        n = 0;
        while (done_count == dc && n < budget) begin
            @(negedge clk); #3;
            n++;
        end
        check({tag, " completes"}, 128'(done_count != dc), 128'(1));
        check({tag, " queues drained"},
              128'(exp_aw_q.size() + exp_ar_q.size() + exp_w_q.size() + exp_done_q.size()), 128'(0));
        @(negedge clk); #3;
        check({tag, " idle after done"}, 128'({busy, done}), 128'(0));
    endtask

    // AXI slave: ready/valid driven just after the falling edge; handshakes that will
    // complete on the next rising edge are booked immediately.
    initial begin
        rsp = '0; b_pend = 0; r_active = 0; wr_beat = 0; r_beat = 0;
        wr_addr = '0; ar_addr = '0; ar_len = '0;
        forever begin
            @(negedge clk); #1;
            if (rst) begin
                rsp = '0; b_pend = 0; r_active = 0; wr_beat = 0; r_beat = 0;
            end else begin
                rsp.aw_ready = 1'b1;
                rsp.ar_ready = 1'b1;
                rsp.w_ready  = !w_stall;
                rsp.b_valid  = b_pend;
                rsp.b.id     = '0;
                rsp.b.resp   = force_slverr ? 2'b10 : 2'b00;
                rd_a = ar_addr + 32'(r_beat * 16);
                rd = mem.exists(rd_a) ? mem[rd_a] : '0;
                if (inj_en && rd_a == inj_addr) rd[5] = ~rd[5];
                rsp.r_valid = r_active;
                rsp.r.id    = '0;
                rsp.r.resp  = 2'b00;
                rsp.r.data  = rd;
                rsp.r.last  = r_active && (r_beat == int'(ar_len));
                if (req.b_ready && rsp.b_valid) b_pend = 0;
                if (req.aw_valid && rsp.aw_ready) begin
                    wr_addr = req.aw.addr; wr_beat = 0;
                end
                if (req.w_valid && rsp.w_ready) begin
                    mem[wr_addr + 32'(wr_beat * 16)] = req.w.data;
                    wr_beat++;
                    if (req.w.last) b_pend = 1;
                end
                if (req.r_ready && rsp.r_valid) begin
                    if (inj_en && rd_a == inj_addr) inj_en = 1'b0;
                    r_beat++;
                    if (r_beat > int'(ar_len)) r_active = 0;
                end
                if (req.ar_valid && rsp.ar_ready) begin
                    ar_addr = req.ar.addr; ar_len = req.ar.len; r_beat = 0; r_active = 1;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT completes a handshake or pulses done.
    initial begin
        logic [39:0]  e_ax;
        logic [128:0] e_w;
        logic [47:0]  e_d;
        forever begin
            @(negedge clk); #2;
            if (!rst) begin
                if (req.aw_valid && rsp.aw_ready) begin
                    if (exp_aw_q.size() == 0) unexpected("aw");
                    else begin
                        e_ax = exp_aw_q.pop_front();
                        check("aw", 128'({req.aw.addr, req.aw.len, req.aw.size, req.aw.burst, req.aw.id}),
                              128'({e_ax, 3'd4, 2'b01, 6'd0}));
                    end
                end
                if (req.ar_valid && rsp.ar_ready) begin
                    if (exp_ar_q.size() == 0) unexpected("ar");
                    else begin
                        e_ax = exp_ar_q.pop_front();
                        check("ar", 128'({req.ar.addr, req.ar.len, req.ar.size, req.ar.burst, req.ar.id}),
                              128'({e_ax, 3'd4, 2'b01, 6'd0}));
                    end
                end
                if (req.w_valid && rsp.w_ready) begin
                    if (exp_w_q.size() == 0) unexpected("w");
                    else begin
                        e_w = exp_w_q.pop_front();
                        check("wdata", req.w.data, e_w[127:0]);
                        check("wlast_wstrb", 128'({req.w.last, req.w.strb}), 128'({e_w[128], 16'hFFFF}));
                    end
                end
                if (done) begin
                    done_count++;
                    if (exp_done_q.size() == 0) unexpected("done");
                    else begin
                        e_d = exp_done_q.pop_front();
                        check("done err_cnt/first_err_addr", 128'({err_cnt, first_err}), 128'(e_d));
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of run expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dc;
        int i;
        rst = 1'b1; start = 1'b0; base = '0; num = '0; blen = '0; seed = '0;
        repeat (3) @(negedge clk);
        #3;
        check("reset valids/readys", 128'({req.aw_valid, req.w_valid, req.b_ready, req.ar_valid, req.r_ready}), 128'(0));
        check("reset busy/done", 128'({busy, done}), 128'(0));
        check("reset err_cnt", 128'(err_cnt), 128'(0));
        check("reset first_err_addr", 128'(first_err), 128'(0));
        @(negedge clk);
        rst = 1'b0;

        // 1: single len-0 burst at 0, seed 0 -> lane k = 4k
        exp_aw_q.push_back({32'h0, 8'd0});
        exp_ar_q.push_back({32'h0, 8'd0});
        exp_w_q.push_back({1'b1, 128'h0000000c_00000008_00000004_00000000});
        exp_done_q.push_back({16'd0, 32'h0});
        dc = done_count;
        start_run(32'h0, 16'd1, 8'd0, 32'h0);
        #3;
        check("busy after start", 128'(busy), 128'(1));
        run_wait(dc, 200, "t1");

        // 2: 0xFC0, len 3, two bursts -> 0xFC0 then 0x1000
        push_burst(32'hFC0, 8'd3, 32'hA5A5_0000);
        push_burst(32'h1000, 8'd3, 32'hA5A5_0000);
        exp_done_q.push_back({16'd0, 32'h0});
        dc = done_count;
        start_run(32'hFC0, 16'd2, 8'd3, 32'hA5A5_0000);
        run_wait(dc, 400, "t2");

        // 2b: 128-byte burst at 0xFC0 would straddle a page -> 0x1000, then 0x1080
        push_burst(32'h1000, 8'd7, 32'h1234_5678);
        push_burst(32'h1080, 8'd7, 32'h1234_5678);
        exp_done_q.push_back({16'd0, 32'h0});
        dc = done_count;
        start_run(32'hFC0, 16'd2, 8'd7, 32'h1234_5678);
        run_wait(dc, 400, "t2b");

        // 3: top of region -> second burst wraps to base
        push_burst(32'hFF_FFC0, 8'd3, 32'hDEAD_BEEF);
        push_burst(32'hFF_FFC0, 8'd3, 32'hDEAD_BEEF);
        exp_done_q.push_back({16'd0, 32'h0});
        dc = done_count;
        start_run(32'hFF_FFC0, 16'd2, 8'd3, 32'hDEAD_BEEF);
        run_wait(dc, 400, "t3");

        // 4: flipped read bit at beat 2 of burst 0x100 -> one error at 0x120
        inj_addr = 32'h120; inj_en = 1'b1;
        push_burst(32'h100, 8'd3, 32'h0F0F_0F0F);
        push_burst(32'h140, 8'd3, 32'h0F0F_0F0F);
        exp_done_q.push_back({16'd1, 32'h120});
        dc = done_count;
        start_run(32'h100, 16'd2, 8'd3, 32'h0F0F_0F0F);
        run_wait(dc, 400, "t4");

        // 5: SLVERR on every B, three bursts -> three errors, first at run base
        force_slverr = 1'b1;
        push_burst(32'h200, 8'd1, 32'h0);
        push_burst(32'h220, 8'd1, 32'h0);
        push_burst(32'h240, 8'd1, 32'h0);
        exp_done_q.push_back({16'd3, 32'h200});
        dc = done_count;
        start_run(32'h200, 16'd3, 8'd1, 32'h0);
        run_wait(dc, 400, "t5");
        force_slverr = 1'b0;

        // 7: burst_len 20 clamps to 15; error count from previous run is cleared
        push_burst(32'h0, 8'd15, 32'h55AA_55AA);
        exp_done_q.push_back({16'd0, 32'h0});
        dc = done_count;
        start_run(32'h0, 16'd1, 8'd20, 32'h55AA_55AA);
        run_wait(dc, 400, "t7");

        // 6: reset while W is stalled, then a zero-burst run
        w_stall = 1'b1;
        push_burst(32'h300, 8'd3, 32'h0);
        start_run(32'h300, 16'd1, 8'd3, 32'h0);
        for (i = 0; i < 50; i++) begin
            @(negedge clk); #3;
            if (req.w_valid) break;
        end
        check("t6 w_valid reached", 128'(req.w_valid), 128'(1));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #3;
        check("t6 valids after reset", 128'({req.aw_valid, req.w_valid, req.b_ready, req.ar_valid, req.r_ready}), 128'(0));
        check("t6 busy after reset", 128'(busy), 128'(0));
        rst = 1'b0;
        w_stall = 1'b0;
        exp_aw_q.delete(); exp_ar_q.delete(); exp_w_q.delete();
        exp_done_q.push_back({16'd0, 32'h0});
        dc = done_count;
        start_run(32'h0, 16'd0, 8'd0, 32'h0);
        #3;
        check("t6 num=0 done next cycle", 128'(done), 128'(1));
        run_wait(dc, 20, "t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
